// File: rtl/hog_norm_div.sv
// hog_norm_div
//   Normalizes a HOG block bin by bin. For each bin it computes
//   min(floor(bin * 2^FRAC_W / magnitude), 2^FRAC_W - 1). The division is
//   restoring and produces one quotient bit per cycle. Only one bin is in
//   flight at a time.
//
// Ports
//   clk, clr          clock (rising edge) and synchronous active-high reset
//   start, magnitude  start a block; magnitude is latched with start in IDLE
//   bin_valid/bin_ready/bin_in      bin input handshake
//   norm_valid/norm_ready/norm_out  normalized output handshake (0.FRAC_W)
//   norm_last         norm_out is the final bin of the block
//   busy              block in progress (any state other than IDLE)
//   done              one-cycle pulse after the final output handshake
module hog_norm_div #(
  parameter int NBINS  = 36,
  parameter int BIN_W  = 8,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [15:0]       magnitude,
  input  logic              bin_valid,
  input  logic [BIN_W-1:0]  bin_in,
  output logic              bin_ready,
  output logic              norm_valid,
  input  logic              norm_ready,
  output logic [FRAC_W-1:0] norm_out,
  output logic              norm_last,
  output logic              busy,
  output logic              done
);
  localparam int DW    = BIN_W + FRAC_W;
  localparam int CNT_W = (NBINS > 1) ? $clog2(NBINS) : 1;
  localparam int STP_W = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, OUT} state_t;

  state_t           state;
  logic [15:0]      mag_r;
  logic [CNT_W-1:0] bin_cnt;
  logic [DW-1:0]    dvd_r;   // dividend; the MSB shifts into the remainder
  logic [DW-1:0]    quo_r;
  logic [15:0]      rem_r;   // always < mag_r, so 16 bits hold it
  logic [STP_W-1:0] step_r;

  // One restoring-division step. rem_sh needs a 17th bit because it can reach
  // 2*mag_r-1. When it is subtracted, the difference is < mag_r, so the low
  // 16 bits are exact.
  logic [16:0]       rem_sh;
  logic [15:0]       rem_sub;
  logic              qbit;
  logic [DW-1:0]     quo_nx;
  logic [FRAC_W-1:0] res;
  logic              last_bin;

  always_comb begin
    rem_sh  = {rem_r, dvd_r[DW-1]};
    rem_sub = rem_sh[15:0] - mag_r;
    qbit    = (rem_sh >= {1'b0, mag_r});
    quo_nx  = {quo_r[DW-2:0], qbit};
    // With a zero divisor every step "subtracts", so the quotient is all ones.
    // Force the result to zero instead.
    if (mag_r == '0)
      res = '0;
    else if (|quo_nx[DW-1:FRAC_W])
      res = '1;                        // saturate at 2^FRAC_W-1
    else
      res = quo_nx[FRAC_W-1:0];
  end

  assign last_bin = (bin_cnt == CNT_W'(NBINS - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      mag_r      <= '0;
      bin_cnt    <= '0;
      dvd_r      <= '0;
      quo_r      <= '0;
      rem_r      <= '0;
      step_r     <= '0;
      bin_ready  <= 1'b0;
      norm_valid <= 1'b0;
      norm_out   <= '0;
      norm_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mag_r     <= magnitude;
          bin_cnt   <= '0;
          bin_ready <= 1'b1;
          busy      <= 1'b1;
          state     <= LOAD;
        end
        LOAD: if (bin_valid) begin
          dvd_r     <= {bin_in, {FRAC_W{1'b0}}};
          quo_r     <= '0;
          rem_r     <= '0;
          step_r    <= '0;
          bin_ready <= 1'b0;
          state     <= DIV;
        end
        DIV: begin
          dvd_r  <= dvd_r << 1;
          rem_r  <= qbit ? rem_sub : rem_sh[15:0];
          quo_r  <= quo_nx;
          step_r <= step_r + 1'b1;
          // The final step writes the result straight into the output register.
          // This makes norm_valid rise on the edge that ends the last DIV cycle.
          if (step_r == STP_W'(DW - 1)) begin
            norm_out   <= res;
            norm_last  <= last_bin;
            norm_valid <= 1'b1;
            state      <= OUT;
          end
        end
        OUT: if (norm_ready) begin
          norm_valid <= 1'b0;
          norm_last  <= 1'b0;
          if (last_bin) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            bin_cnt   <= bin_cnt + 1'b1;
            bin_ready <= 1'b1;
            state     <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
